baud_tick_gen: RTL

Programmable baud-rate tick generator, the parametrised successor of the fixed 16x oversampling generator used by the UART receiver. It produces a one-cycle oversampling strobe plus a bit-rate strobe and a phase index. The divisor is reprogrammable at run time through a glitch-free shadow register that only takes effect on a tick boundary. It sits between the board clock and the UART RX/TX datapaths, and one instance can drive both directions.

---
 rtl/baud_pkg.sv | 32 +++
 rtl/tick_divider.sv | 136 +++++++++++++
 rtl/baud_tick_gen.sv | 78 +++++++
 3 files changed

// File: rtl/baud_pkg.sv
// Shared constants and elaboration-time helpers for the baud tick generator.
// Latency: n/a (package). Backpressure: n/a.
// Provides default widths and the divisor/fraction derivation from clock and baud rate.
package baud_pkg;

  localparam int NUM_TICKS_DEF = 16;
  localparam int DIV_W_DEF     = 16;
  localparam int PHASE_W_DEF   = $clog2(NUM_TICKS_DEF);
  localparam int FRAC_W        = 4;

  // Whole clock cycles per oversampling tick, truncated.
  function automatic longint calc_div(input longint clk_rate, input longint baud,
                                      input longint num_ticks);
    return clk_rate / (baud * num_ticks);
  endfunction

  // Fractional part of the ideal divisor in sixteenths, rounded to nearest.
  // Rounding up into the next whole cycle is clamped to 15 so the result
  // always fits the accumulator step.
  function automatic longint calc_frac(input longint clk_rate, input longint baud,
                                       input longint num_ticks);
    longint den;
    longint x16;
    longint f;
    den = baud * num_ticks;
    x16 = ((clk_rate * 32) / den + 1) / 2;
    f   = x16 - 16 * (clk_rate / den);
    if (f > 15) f = 15;
    return f;
  endfunction

endpackage

// File: rtl/tick_divider.sv
// Reloadable cycle counter producing the oversampling tick, with a shadow divisor register.
// Latency: tick registered the edge after the count reaches the divisor limit.
// Backpressure: none; enable=0 holds the count at zero and suppresses tick.
// Ports: CLK, reset (async, active-high), enable, div_in/div_wr (divisor write),
//        div_pending (shadow waiting for a wrap), tick (registered strobe),
//        wrap (combinational: this edge ends a period; used by the top for phase).
// Optional BAUD_FRAC_EN adds frac_in and a 4-bit fractional accumulator.
module tick_divider
  import baud_pkg::*;
#(
  parameter int               DIV_W       = DIV_W_DEF,
  parameter logic [DIV_W-1:0] DEFAULT_DIV = DIV_W'(1)
`ifdef BAUD_FRAC_EN
  ,
  parameter logic [FRAC_W-1:0] DEFAULT_FRAC = '0
`endif
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              enable,
  input  logic [DIV_W-1:0]  div_in,
  input  logic              div_wr,
`ifdef BAUD_FRAC_EN
  input  logic [FRAC_W-1:0] frac_in,
`endif
  output logic              div_pending,
  output logic              tick,
  output logic              wrap
);

  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] shadow_q;
  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] limit;
  logic [DIV_W-1:0] div_next;

  // Divisor taking effect at a wrap: a same-cycle write beats the shadow.
  always_comb begin
    div_next = div_q;
    if (div_wr) begin
      div_next = div_in;
    end else if (div_pending) begin
      div_next = shadow_q;
    end
  end

`ifdef BAUD_FRAC_EN
  logic [FRAC_W-1:0] frac_q;
  logic [FRAC_W-1:0] frac_sh_q;
  logic [FRAC_W-1:0] acc_q;
  logic [FRAC_W-1:0] frac_next;
  logic [FRAC_W:0]   acc_sum;
  logic              extra_q;

  always_comb begin
    frac_next = frac_q;
    if (div_wr) begin
      frac_next = frac_in;
    end else if (div_pending) begin
      frac_next = frac_sh_q;
    end
    acc_sum = {1'b0, acc_q} + {1'b0, frac_next};
  end

  // A carry out of the accumulator stretches the following period by one cycle.
  assign limit = ((div_q == '0) ? '0 : div_q - 1'b1) + DIV_W'(extra_q);
`else
  // D=0 behaves as D=1: limit 0, so every enabled cycle wraps.
  assign limit = (div_q == '0) ? '0 : div_q - 1'b1;
`endif

  assign wrap = enable && (cnt_q == limit);

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      div_q       <= DEFAULT_DIV;
      shadow_q    <= DEFAULT_DIV;
      cnt_q       <= '0;
      tick        <= 1'b0;
      div_pending <= 1'b0;
    end else if (!enable) begin
      // Partial count is discarded; a write while idle applies directly.
      cnt_q <= '0;
      tick  <= 1'b0;
      if (div_wr) begin
        div_q       <= div_in;
        shadow_q    <= div_in;
        div_pending <= 1'b0;
      end
    end else begin
      tick <= wrap;
      if (div_wr) begin
        shadow_q <= div_in;
      end
      if (wrap) begin
        cnt_q       <= '0;
        div_q       <= div_next;
        div_pending <= 1'b0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
        if (div_wr) begin
          div_pending <= 1'b1;
        end
      end
    end
  end

`ifdef BAUD_FRAC_EN
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      frac_q    <= DEFAULT_FRAC;
      frac_sh_q <= DEFAULT_FRAC;
      acc_q     <= '0;
      extra_q   <= 1'b0;
    end else if (!enable) begin
      // Restart cleanly so the first period after enable is exactly D.
      acc_q   <= '0;
      extra_q <= 1'b0;
      if (div_wr) begin
        frac_q    <= frac_in;
        frac_sh_q <= frac_in;
      end
    end else begin
      if (div_wr) begin
        frac_sh_q <= frac_in;
      end
      if (wrap) begin
        frac_q  <= frac_next;
        acc_q   <= acc_sum[FRAC_W-1:0];
        extra_q <= acc_sum[FRAC_W];
      end
    end
  end
`endif

endmodule

// File: rtl/baud_tick_gen.sv
// Programmable baud tick generator: oversampling tick, bit-rate tick and phase index.
// Latency: first tick D cycles after enable rises, first bit_tick D*NUM_TICKS cycles.
// Backpressure: none; enable=0 holds phase at 0 and forces tick/bit_tick low.
// Ports: CLK, reset (async, active-high), enable, div_in/div_wr (run-time divisor,
//        applied at the next tick boundary), div_pending, tick, bit_tick, phase.
// Build option BAUD_FRAC_EN adds frac_in (sixteenths of a cycle, sampled on div_wr).
module baud_tick_gen
  import baud_pkg::*;
#(
  parameter longint CLK_RATE     = 40000000,
  parameter longint DEFAULT_BAUD = 9600,
  parameter int     NUM_TICKS    = NUM_TICKS_DEF,
  parameter int     DIV_W        = DIV_W_DEF
) (
  input  logic                         CLK,
  input  logic                         reset,
  input  logic                         enable,
  input  logic [DIV_W-1:0]             div_in,
  input  logic                         div_wr,
`ifdef BAUD_FRAC_EN
  input  logic [FRAC_W-1:0]            frac_in,
`endif
  output logic                         div_pending,
  output logic                         tick,
  output logic                         bit_tick,
  output logic [$clog2(NUM_TICKS)-1:0] phase
);

  localparam int               PHASE_W     = $clog2(NUM_TICKS);
  localparam logic [DIV_W-1:0] DEFAULT_DIV =
    DIV_W'(calc_div(CLK_RATE, DEFAULT_BAUD, longint'(NUM_TICKS)));
`ifdef BAUD_FRAC_EN
  localparam logic [FRAC_W-1:0] DEFAULT_FRAC =
    FRAC_W'(calc_frac(CLK_RATE, DEFAULT_BAUD, longint'(NUM_TICKS)));
`endif
  localparam logic [PHASE_W-1:0] LAST_PHASE = PHASE_W'(NUM_TICKS - 1);

  logic wrap;

  tick_divider #(
    .DIV_W       (DIV_W),
    .DEFAULT_DIV (DEFAULT_DIV)
`ifdef BAUD_FRAC_EN
    ,
    .DEFAULT_FRAC(DEFAULT_FRAC)
`endif
  ) u_div (
    .CLK        (CLK),
    .reset      (reset),
    .enable     (enable),
    .div_in     (div_in),
    .div_wr     (div_wr),
`ifdef BAUD_FRAC_EN
    .frac_in    (frac_in),
`endif
    .div_pending(div_pending),
    .tick       (tick),
    .wrap       (wrap)
  );

  // phase and bit_tick update on the same edge that registers tick, so
  // bit_tick coincides with the tick on which phase returns to 0.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      phase    <= '0;
      bit_tick <= 1'b0;
    end else if (!enable) begin
      phase    <= '0;
      bit_tick <= 1'b0;
    end else begin
      bit_tick <= wrap && (phase == LAST_PHASE);
      if (wrap) begin
        phase <= (phase == LAST_PHASE) ? '0 : phase + 1'b1;
      end
    end
  end

endmodule
